bram_sweep_ctrl: RTL and testbench
==================================

# bram_sweep_ctrl

Sequencer for the 512×512 multi-read BRAM (one write port, sixteen read-address lanes, shared read reset). It accepts a frame of 512-bit rows over a valid/ready stream, writes them to port A, then sweeps all sixteen read lanes across the frame. It marks the BRAM output as valid after the read latency, then rearms for the next frame. It sits between the upstream row producer and the BRAM, and owns every BRAM control pin.

## Interface
Parameters:
- `RD_LAT`, 1: BRAM port-B read latency in cycles, counted from the `addrb` register to valid `doutb`. Legal range 1..4.
- `LANE_STRIDE`, 32: per-lane address offset. Used only when `BRAM_SWEEP_LANE_OFS_EN` is defined.

Ports:
- `clka`: in, 1, single clock. The BRAM `clka` and `clkb` are both driven from it.
- `rstn`: in, 1. Reset is synchronous and active-low.
- `frame_len`: in, 10. Number of rows per frame. 0 or any value ≥512 means 512.
- `s_valid`: in, 1. Upstream row valid.
- `s_ready`: out, 1. Controller can accept a row.
- `s_data`: in, 512. Row payload.
- `wea`: out, 1. BRAM write enable.
- `addra`: out, 9. BRAM write address.
- `dina`: out, 512. BRAM write data.
- `rstb`: out, 1. BRAM read-port reset, active-high. Held at 1 whenever no sweep is running.
- `addrb`: out, 144. Sixteen packed lanes; lane k occupies bits [9k+8:9k].
- `m_valid`: out, 1. `doutb` is valid this cycle.
- `m_last`: out, 1. Marks the final valid row of the sweep.
- `busy`: out, 1. High in SWEEP and FLUSH.
- `frame_done`: out, 1. One-cycle pulse when the sweep completes.

## Operation
- FSM states: FILL, SWEEP, FLUSH.
- Reset values (on a `rstn`=0 edge):
  - state = FILL.
  - `s_ready`=0, `wea`=0, `addra`=0, `dina`=0, `rstb`=1, `addrb`=0.
  - `m_valid`=0, `m_last`=0, `busy`=0, `frame_done`=0.
  - Write pointer and read pointer = 0.
- Frame length latch: `frame_len` is latched into `len` (1..512) on the first cycle after reset and on every FLUSH→FILL transition. Changes to `frame_len` at other times are ignored.
- FILL:
  - `s_ready`=1, except in the cycle after the frame's final accept.
  - Each accept (`s_valid`&&`s_ready`) registers `wea`=1, `addra`=wr_ptr and `dina`=`s_data`, then increments wr_ptr.
  - A cycle with no accept registers `wea`=0; `addra` and `dina` hold their values.
  - On the accept with wr_ptr==`len`-1, the next state is SWEEP, wr_ptr returns to 0 and `s_ready` drops to 0.
- SWEEP:
  - `rstb`=0 and `busy`=1.
  - Each cycle registers base=rd_ptr onto every lane, then increments rd_ptr.
  - When rd_ptr==`len`-1 is issued, the next state is FLUSH and rd_ptr returns to 0.
  - No stall: `s_valid` is ignored in this state.
- FLUSH:
  - Waits `RD_LAT` cycles so the last issued address has its data out.
  - `rstb` stays 0 during the wait.
  - On exit: `rstb`=1, `addrb`=0, `frame_done`=1 for one cycle, next state FILL.
- Valid pipeline: `m_valid` is a shift register of depth `RD_LAT`, fed with 1 in each cycle an address is issued. `m_last` travels alongside it and is tagged on the final issued address.
- Arithmetic: all addresses are 9-bit and wrap modulo 512.
- Reset mid-operation: the partial frame is discarded, the valid pipeline is cleared, and all outputs take their reset values on the next edge.

## Timing
- Write latency: an accept at edge N gives `wea`/`addra`/`dina` visible after edge N.
- First read: `rstb` falls and `addrb` shows lane base 0 on the edge after the frame's final write is registered. The BRAM write and the first read are therefore never in the same cycle.
- Read data: an address issued at edge M gives `m_valid`=1 after edge M+`RD_LAT`.
- Frame cycle length: a `len`-row frame with `s_valid` held high takes `len` (FILL) + `len` (SWEEP) + `RD_LAT` (FLUSH) cycles.
- `frame_done` is coincident with the cycle after the final `m_valid` and `m_last`.
- `s_ready` returns to 1 in the same cycle as `frame_done`.
- `len`=1: FILL accepts one row, SWEEP issues one address, and `m_valid` and `m_last` assert together for that single row.

## Configuration
- `BRAM_SWEEP_LANE_OFS_EN` defined: lane k = (base + k·`LANE_STRIDE`) mod 512, giving sixteen staggered read streams.
- Not defined: all sixteen lanes equal base, and `LANE_STRIDE` is unused.

## Test plan
- Reset: hold `rstn`=0 for 3 cycles with `s_valid`=1. Expect all outputs at their reset values, `rstb`=1 and `s_ready`=0; one cycle after release, `s_ready`=1.
- Full frame: `frame_len`=0, `s_data`=row index, `s_valid` held high, `RD_LAT`=1.
  - Expect 512 writes with `addra` 0..511 and `s_ready`=0 from cycle 513.
  - Then `addrb` lane 0 sweeps 0..511, `m_valid` asserts for exactly 512 cycles, and `m_last` falls on the 512th.
  - `frame_done` arrives on cycle 1026 after the first accept.
- Throttled fill: `frame_len`=4 with `s_valid` toggling 1,0,1,0…. Expect exactly 4 writes to addresses 0..3, `wea`=0 in the gap cycles, and SWEEP entered only after the 4th accept.
- Lane offset (macro on, `LANE_STRIDE`=32, `frame_len`=20): at base 19, expect lane 15 = (19+480) mod 512 = 499. With base advanced to 0 and lane 1 at 32, repeat with the macro off and expect every lane equal to base.
- Latency sweep: `RD_LAT`=3, `frame_len`=1. Expect the address issued at edge M, `m_valid` and `m_last` high only at M+3, `frame_done` at M+4, and `rstb` back to 1 at M+4.
- Mid-sweep reset: assert `rstn`=0 while base=100. Expect `m_valid`=0, `rstb`=1 and state FILL on the next edge. A new 2-row frame then writes to `addra` 0 and 1.

Source files
------------

// File: rtl/bram_sweep_ctrl.sv
// bram_sweep_ctrl: fills a 512x512 multi-read BRAM from a row stream, then sweeps all sixteen read lanes; define BRAM_SWEEP_LANE_OFS_EN to stagger lanes by LANE_STRIDE
module bram_sweep_ctrl #(
  parameter int RD_LAT = 1,
  parameter int LANE_STRIDE = 32
) (
  input  logic         clka,
  input  logic         rstn,
  input  logic [9:0]   frame_len,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [511:0] s_data,
  output logic         wea,
  output logic [8:0]   addra,
  output logic [511:0] dina,
  output logic         rstb,
  output logic [143:0] addrb,
  output logic         m_valid,
  output logic         m_last,
  output logic         busy,
  output logic         frame_done
);
  typedef enum logic [1:0] {FILL, SWEEP, FLUSH} state_t;
  state_t state, state_nx;
  logic init;
  logic [8:0] lm1, wr_ptr, rd_ptr;
  logic [2:0] fl_cnt;
  logic [RD_LAT:0] vpipe, lpipe;
  logic [143:0] lanes;
  logic accept, issue, fl_exit, wr_last, rd_last;

  if (RD_LAT < 1 || RD_LAT > 4 || LANE_STRIDE < 0) begin : g_bad_param
    $error("bram_sweep_ctrl: RD_LAT must be 1..4 and LANE_STRIDE non-negative");
  end

  assign accept  = state == FILL && s_valid && s_ready;
  assign issue   = state == SWEEP;
  assign wr_last = wr_ptr == lm1;
  assign rd_last = rd_ptr == lm1;
  assign fl_exit = state == FLUSH && fl_cnt == 3'(RD_LAT);
  assign busy    = state != FILL;
  assign m_valid = vpipe[RD_LAT];
  assign m_last  = lpipe[RD_LAT];

  // lane addresses for the row currently being issued
  always_comb begin
    lanes = '0;
    for (int k = 0; k < 16; k++)
`ifdef BRAM_SWEEP_LANE_OFS_EN
      lanes[9*k +: 9] = rd_ptr + 9'(k * LANE_STRIDE);
`else
      lanes[9*k +: 9] = rd_ptr;
`endif
  end

  // next state: final accept starts the sweep, final issue starts the flush
  always_comb begin
    state_nx = (accept && wr_last) ? SWEEP :
               (issue && rd_last)  ? FLUSH :
               fl_exit             ? FILL  : state;
  end

  // state register
  always_ff @(posedge clka) state <= !rstn ? FILL : state_nx;

  // datapath: write port, read sweep, valid pipeline and frame bookkeeping
  always_ff @(posedge clka) begin
    if (!rstn) begin
      init       <= 1'b1;
      lm1        <= '0;
      s_ready    <= 1'b0;
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      rstb       <= 1'b1;
      addrb      <= '0;
      frame_done <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fl_cnt     <= '0;
      vpipe      <= '0;
      lpipe      <= '0;
    end else begin
      init       <= 1'b0;
      lm1        <= (init || fl_exit) ? ((frame_len[9] || frame_len == '0) ? 9'h1ff : frame_len[8:0] - 9'd1) : lm1;
      s_ready    <= init || fl_exit || (s_ready && !(accept && wr_last));
      wea        <= accept;
      addra      <= accept ? wr_ptr : addra;
      dina       <= accept ? s_data : dina;
      wr_ptr     <= accept ? (wr_last ? 9'd0 : wr_ptr + 9'd1) : wr_ptr;
      rd_ptr     <= issue ? (rd_last ? 9'd0 : rd_ptr + 9'd1) : rd_ptr;
      addrb      <= issue ? lanes : fl_exit ? 144'd0 : addrb;
      rstb       <= issue ? 1'b0 : fl_exit ? 1'b1 : rstb;
      frame_done <= fl_exit;
      fl_cnt     <= state == FLUSH ? fl_cnt + 3'd1 : 3'd0;
      vpipe      <= {vpipe[RD_LAT-1:0], issue};
      lpipe      <= {lpipe[RD_LAT-1:0], issue && rd_last};
    end
  end
endmodule

// File: tb/tb_bram_sweep_ctrl.sv
// tb_bram_sweep_ctrl: two controllers (read latency 1 and 3) on a shared random stream, checked every cycle against a frame-timeline model
module tb_bram_sweep_ctrl;
  logic clka = 1'b0;
  logic rstn, s_valid;
  logic [9:0] frame_len;
  logic [511:0] s_data;
  logic s_ready_o[2], wea_o[2], rstb_o[2], m_valid_o[2], m_last_o[2], busy_o[2], frame_done_o[2];
  logic [8:0] addra_o[2];
  logic [511:0] dina_o[2];
  logic [143:0] addrb_o[2];

  always #5 clka = ~clka;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bram_sweep_ctrl #(.RD_LAT(g == 0 ? 1 : 3), .LANE_STRIDE(32)) u_dut (
      .clka(clka), .rstn(rstn), .frame_len(frame_len),
      .s_valid(s_valid), .s_ready(s_ready_o[g]), .s_data(s_data),
      .wea(wea_o[g]), .addra(addra_o[g]), .dina(dina_o[g]),
      .rstb(rstb_o[g]), .addrb(addrb_o[g]),
      .m_valid(m_valid_o[g]), .m_last(m_last_o[g]),
      .busy(busy_o[g]), .frame_done(frame_done_o[g])
    );
  end

  int errors = 0, checks = 0, t = 0;
  int lat[2] = '{1, 3};
  int len_m[2], acc[2], fin[2] = '{-1, -1};
  bit fresh[2];
  bit e_ready[2], e_wea[2], e_rstb[2], e_mv[2], e_ml[2], e_busy[2], e_done[2];
  logic [8:0] e_addra[2];
  logic [511:0] e_dina[2];
  logic [143:0] e_addrb[2];

  function automatic int dec(logic [9:0] f);
    return (f == 0 || f >= 512) ? 512 : int'(f);
  endfunction

  function automatic logic [143:0] lanes_of(int base);
    logic [143:0] r;
    int ofs = 0;
`ifdef BRAM_SWEEP_LANE_OFS_EN
    ofs = 32;
`endif
    for (int j = 0; j < 16; j++) r[9*j +: 9] = 9'((base + j * ofs) % 512);
    return r;
  endfunction

  task automatic chk(string tag, int d, logic [511:0] obs, logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // frame timeline: expected outputs follow from accept count and distance to the final accept
  task automatic model_step(int d);
    int k;
    if (!rstn) begin
      fresh[d] = 1; acc[d] = 0; fin[d] = -1;
      e_ready[d] = 0; e_wea[d] = 0; e_addra[d] = '0; e_dina[d] = '0;
      e_rstb[d] = 1; e_addrb[d] = '0; e_mv[d] = 0; e_ml[d] = 0; e_done[d] = 0;
    end else begin
      e_wea[d] = 0; e_done[d] = 0; e_mv[d] = 0; e_ml[d] = 0;
      if (fin[d] < 0) begin
        if (fresh[d]) begin
          len_m[d] = dec(frame_len); fresh[d] = 0; e_ready[d] = 1;
        end else if (s_valid && e_ready[d]) begin
          e_wea[d] = 1; e_addra[d] = 9'(acc[d]); e_dina[d] = s_data; acc[d]++;
          if (acc[d] == len_m[d]) begin fin[d] = t; e_ready[d] = 0; end
        end
      end else begin
        k = t - fin[d];
        if (k <= len_m[d]) begin e_addrb[d] = lanes_of(k - 1); e_rstb[d] = 0; end
        if (k - lat[d] >= 1 && k - lat[d] <= len_m[d]) begin
          e_mv[d] = 1; e_ml[d] = (k - lat[d] == len_m[d]);
        end
        if (k == len_m[d] + lat[d] + 1) begin
          e_done[d] = 1; e_rstb[d] = 1; e_addrb[d] = '0; e_ready[d] = 1;
          len_m[d] = dec(frame_len); fin[d] = -1; acc[d] = 0;
        end
      end
    end
    e_busy[d] = fin[d] >= 0;
  endtask

  task automatic check_all(int d);
    chk("s_ready", d, s_ready_o[d], e_ready[d]);
    chk("wea", d, wea_o[d], e_wea[d]);
    chk("addra", d, addra_o[d], e_addra[d]);
    chk("dina", d, dina_o[d], e_dina[d]);
    chk("rstb", d, rstb_o[d], e_rstb[d]);
    chk("addrb", d, addrb_o[d], e_addrb[d]);
    chk("m_valid", d, m_valid_o[d], e_mv[d]);
    chk("m_last", d, m_last_o[d], e_ml[d]);
    chk("busy", d, busy_o[d], e_busy[d]);
    chk("frame_done", d, frame_done_o[d], e_done[d]);
  endtask

  task automatic cyc();
    @(posedge clka);
    t++;
    for (int d = 0; d < 2; d++) model_step(d);
    #1;
    for (int d = 0; d < 2; d++) check_all(d);
    for (int i = 0; i < 16; i++) s_data[32*i +: 32] = $urandom;
  endtask

  task automatic do_reset(int n, logic [9:0] fl);
    rstn = 1'b0;
    repeat (n) cyc();
    frame_len = fl;
    rstn = 1'b1;
  endtask

  initial begin
    int first_acc, done_at, mv_cnt, issue_t, mv_t, n, exp15;
    rstn = 1'b0; s_valid = 1'b1; frame_len = 10'd0;
    for (int i = 0; i < 16; i++) s_data[32*i +: 32] = $urandom;
    repeat (3) cyc();
    chk("reset_s_ready", 0, s_ready_o[0], 1'b0);
    chk("reset_rstb", 1, rstb_o[1], 1'b1);
    rstn = 1'b1;
    cyc();
    cyc();
    chk("ready_after_release", 0, s_ready_o[0], 1'b1);

    first_acc = -1; done_at = -1; mv_cnt = 0;
    if (wea_o[0]) first_acc = t;
    for (int i = 0; i < 1040; i++) begin
      cyc();
      if (wea_o[0] && first_acc < 0) first_acc = t;
      if (frame_done_o[0] && done_at < 0) done_at = t;
      mv_cnt += int'(m_valid_o[0]);
    end
    chk("full_done_cycle", 0, done_at - first_acc + 1, 1026);
    chk("full_mvalid_cycles", 0, mv_cnt, 512);

    do_reset(1, 10'd4);
    for (int i = 0; i < 40; i++) begin s_valid = (i % 2 == 1); cyc(); end

    exp15 = 19;
`ifdef BRAM_SWEEP_LANE_OFS_EN
    exp15 = 499;
`endif
    do_reset(2, 10'd20);
    s_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (!rstb_o[0] && addrb_o[0][8:0] == 9'd19) chk("lane15_at_base19", 0, addrb_o[0][143:135], 9'(exp15));
    end

    do_reset(1, 10'd1);
    issue_t = -1; mv_t = -1; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (!rstb_o[1] && issue_t < 0) issue_t = t;
      if (m_valid_o[1] && m_last_o[1] && mv_t < 0) mv_t = t;
      if (frame_done_o[1] && done_at < 0) done_at = t;
    end
    chk("lat3_valid_delay", 1, mv_t - issue_t, 3);
    chk("lat3_done_delay", 1, done_at - issue_t, 4);

    for (int f = 0; f < 5; f++) begin
      do_reset(1, 10'($urandom_range(0, 40)));
      repeat (200) begin
        s_valid = ($urandom_range(0, 3) != 0);
        frame_len = 10'($urandom_range(0, 40));
        cyc();
      end
    end

    do_reset(1, 10'd700);
    repeat (1300) begin s_valid = ($urandom_range(0, 3) != 0); cyc(); end

    do_reset(1, 10'd200);
    s_valid = 1'b1;
    n = 0;
    while (!(busy_o[0] && !rstb_o[0] && addrb_o[0][8:0] == 9'd100) && n < 600) begin cyc(); n++; end
    chk("midsweep_reached", 0, n < 600, 1'b1);
    rstn = 1'b0;
    cyc();
    chk("midsweep_mvalid", 0, m_valid_o[0], 1'b0);
    chk("midsweep_rstb", 0, rstb_o[0], 1'b1);
    frame_len = 10'd2;
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin s_valid = ($urandom_range(0, 1) != 0); cyc(); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
